snac_db15_scanner: RTL and testbench

- Serial front end for the SNAC DB15 adapter on the MiSTer user port.
- Reads 24 button and direction bits, 12 per player, from the adapter's shift-register chain.
- Drives JOY_CLK/JOY_LOAD onto USER_OUT[1:0]; reads JOY_DATA from USER_IN[5].
- Delivers filtered, active-high 16-bit joystick words to the top-level input mapping, which gates them with the DB15 device menu selection.

---
 rtl/snac_db15_scanner.sv | 152 +++++++++++++++
 tb/tb_snac_db15_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snac_db15_scanner.sv
// SNAC DB15 serial front end: scans 24 active-low bits from the adapter shift chain
// Latency: one full scan (FILTER=0) or two identical scans (FILTER=1) from input change to output
// Backpressure: none; free-running scanner, results presented with a one-cycle scan_done pulse
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            1 = scanning allowed; a scan in flight always completes
//   JOY_DATA          serial data from adapter (asynchronous, active-low buttons)
//   JOY_CLK, JOY_LOAD shift clock and active-low parallel-load strobe to the adapter
//   joystick1/2       active-high button words, [11:0] = R,L,D,U,A,B,C,D,E,F,Start,Select
//   present           last accepted scan was not all-zero on the line
//   scan_done         one-cycle pulse when a scan completes (outputs update in that cycle)
module snac_db15_scanner #(
  parameter int CLK_DIV  = 64,
  parameter int SCAN_GAP = 5360,
  parameter int FILTER   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        present,
  output logic        scan_done
);

  localparam int CNT_MAX = (SCAN_GAP > CLK_DIV) ? SCAN_GAP : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SCAN_GAP - 1);
  localparam bit NO_FILTER = (FILTER == 0);

  typedef enum logic [2:0] {GAP, LOAD, CLK_LO, CLK_HI, DONE} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [4:0]  idx;
  logic [23:0] raw;
  logic [23:0] prev;
  logic        data_meta;
  logic        data_sync;
  logic        raw_zero;
  logic        take_new;

  // raw is complete by the time CLK_HI of bit 23 ends, so the update is made
  // on the edge entering DONE; outputs and scan_done then appear together.
  always_comb begin
    raw_zero = (raw == 24'd0);
    take_new = NO_FILTER || (raw == prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      state     <= GAP;
      cnt       <= '0;
      idx       <= '0;
      raw       <= '1;
      prev      <= '1;
      JOY_CLK   <= 1'b0;
      JOY_LOAD  <= 1'b1;
      joystick1 <= '0;
      joystick2 <= '0;
      present   <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      data_meta <= JOY_DATA;
      data_sync <= data_meta;
      scan_done <= 1'b0;

      case (state)
        GAP: begin
          // Disabled: park with the counter cleared so a re-enable waits a full gap.
          if (!enable) begin
            cnt <= '0;
          end else if (cnt == GAP_LAST) begin
            cnt      <= '0;
            JOY_LOAD <= 1'b0;
            state    <= LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        LOAD: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            idx      <= '0;
            JOY_LOAD <= 1'b1;
            state    <= CLK_LO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        CLK_LO: begin
          if (cnt == DIV_LAST) begin
            // Sample just before the rising edge shifts the next bit out.
            raw[idx] <= data_sync;
            cnt      <= '0;
            JOY_CLK  <= 1'b1;
            state    <= CLK_HI;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        CLK_HI: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            JOY_CLK <= 1'b0;
            if (idx == 5'd23) begin
              state     <= DONE;
              scan_done <= 1'b1;
              prev      <= raw;
              if (raw_zero) begin
                // Line stuck low or adapter absent.
                present   <= 1'b0;
                joystick1 <= '0;
                joystick2 <= '0;
              end else if (take_new) begin
                present   <= 1'b1;
                joystick1 <= {4'h0, ~raw[11:0]};
                joystick2 <= {4'h0, ~raw[23:12]};
              end
            end else begin
              idx   <= idx + 5'd1;
              state <= CLK_LO;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          cnt   <= '0;
          state <= GAP;
        end

        default: begin
          cnt   <= '0;
          state <= GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snac_db15_scanner.sv
// Bench for snac_db15_scanner: unfiltered and filtered instances share one adapter model
// Latency: expectations are queued per scan and checked at each scan_done
// Backpressure: n/a
module tb_snac_db15_scanner;

  typedef logic [32:0] exp_t; // {present, joystick2, joystick1}

  localparam logic [23:0] IDLE  = 24'hFFFFFF;
  localparam logic [23:0] P_RS  = 24'hBFFFFE; // raw[0]=0 (P1 Right), raw[22]=0 (P2 Start)
  localparam logic [23:0] P_A   = 24'hFFFFEF; // raw[4]=0 (P1 A)
  localparam logic [23:0] P_R   = 24'hFFFFFE; // raw[0]=0

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        joy_data;
  logic        joy_clk0, joy_load0, present0, done0;
  logic        joy_clk1, joy_load1, present1, done1;
  logic [15:0] j1_0, j2_0, j1_1, j2_1;

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  snac_db15_scanner #(.CLK_DIV(4), .SCAN_GAP(8), .FILTER(0)) u_f0 (
    .clk(clk), .reset(reset), .enable(enable), .JOY_DATA(joy_data),
    .JOY_CLK(joy_clk0), .JOY_LOAD(joy_load0), .joystick1(j1_0), .joystick2(j2_0),
    .present(present0), .scan_done(done0)
  );

  snac_db15_scanner #(.CLK_DIV(4), .SCAN_GAP(8), .FILTER(1)) u_f1 (
    .clk(clk), .reset(reset), .enable(enable), .JOY_DATA(joy_data),
    .JOY_CLK(joy_clk1), .JOY_LOAD(joy_load1), .joystick1(j1_1), .joystick2(j2_1),
    .present(present1), .scan_done(done1)
  );

  // Adapter model: parallel load while LOAD is low, shift toward bit 0 on JOY_CLK rise.
  logic [23:0] pattern = IDLE;
  logic [23:0] sh = IDLE;
  logic        stuck = 1'b0;
  logic        clk_q = 1'b0;

  always @(posedge clk) begin
    clk_q <= joy_clk0;
    if (!joy_load0) sh <= pattern;
    else if (joy_clk0 && !clk_q) sh <= {1'b1, sh[23:1]};
  end

  assign joy_data = stuck ? 1'b0 : sh[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one queued expectation per scan_done per instance.
  always @(negedge clk) begin
    if (!reset && done0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL f0_unexpected_scan_done: got pulse expected none");
      end else begin
        e0 = q0.pop_front();
        check("f0_scan_outputs", {31'd0, present0, j2_0, j1_0}, {31'd0, e0});
      end
    end
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL f1_unexpected_scan_done: got pulse expected none");
      end else begin
        e1 = q1.pop_front();
        check("f1_scan_outputs", {31'd0, present1, j2_1, j1_1}, {31'd0, e1});
      end
    end
  end

  task automatic push(input exp_t a, input exp_t b);
    q0.push_back(a);
    q1.push_back(b);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done0 && n < 1000);
    if (!done0) begin
      checks++; errors++;
      $display("FAIL scan_done_timeout: got none expected pulse within 1000 cycles");
    end
  endtask

  task automatic do_scan(input logic [23:0] p, input logic st, input exp_t a, input exp_t b,
                         output int n);
    pattern = p;
    stuck   = st;
    push(a, b);
    wait_done(n);
  endtask

  task automatic wait_load_fall(output int n);
    n = 0;
    while (joy_load0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_load_rise();
    int k;
    k = 0;
    while (!joy_load0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_rises(input int target);
    int k, r;
    logic pc;
    k = 0; r = 0; pc = joy_clk0;
    while (r < target && k < 1000) begin
      @(negedge clk);
      k++;
      if (joy_clk0 && !pc) r++;
      pc = joy_clk0;
    end
    if (r != target) check("clk_rise_wait", 64'(r), 64'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, k, hi, lo, rises, act;
    logic pc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_joy_clk",  64'(joy_clk0),  64'd0);
    check("rst_joy_load", 64'(joy_load0), 64'd1);
    check("rst_f0_outs",  64'({present0, j2_0, j1_0, done0}), 64'd0);
    check("rst_f1_outs",  64'({present1, j2_1, j1_1, done1}), 64'd0);

    // Scan 1: timing of load strobe and shift clock, idle adapter
    reset = 1'b0;
    pattern = IDLE;
    push({1'b1, 16'h0000, 16'h0000}, {1'b1, 16'h0000, 16'h0000});
    wait_load_fall(n);
    check("gap_after_reset", 64'(n), 64'd8);
    m = 0;
    while (!joy_load0 && m < 100) begin
      m++;
      @(negedge clk);
    end
    check("load_low_cycles", 64'(m), 64'd4);
    hi = 0; lo = 0; rises = 0; pc = 1'b0; k = 0;
    while (!done0 && k < 400) begin
      if (joy_clk0) hi++; else lo++;
      if (joy_clk0 && !pc) rises++;
      pc = joy_clk0;
      @(negedge clk);
      k++;
    end
    check("clk_pulses", 64'(rises), 64'd24);
    check("clk_high_cycles", 64'(hi), 64'd96);
    check("clk_low_cycles", 64'(lo), 64'd96);

    // Scan 2: period
    do_scan(IDLE, 1'b0, {1'b1, 16'h0000, 16'h0000}, {1'b1, 16'h0000, 16'h0000}, n);
    check("scan_period", 64'(n), 64'd205);

    // Bit mapping: P1 Right and P2 Start
    do_scan(P_RS, 1'b0, {1'b1, 16'h0400, 16'h0001}, {1'b1, 16'h0000, 16'h0000}, n);
    do_scan(P_RS, 1'b0, {1'b1, 16'h0400, 16'h0001}, {1'b1, 16'h0400, 16'h0001}, n);
    do_scan(IDLE, 1'b0, {1'b1, 16'h0000, 16'h0000}, {1'b1, 16'h0400, 16'h0001}, n);
    do_scan(IDLE, 1'b0, {1'b1, 16'h0000, 16'h0000}, {1'b1, 16'h0000, 16'h0000}, n);

    // Filtering: one-scan glitch on P1 A, then held for two scans
    do_scan(P_A,  1'b0, {1'b1, 16'h0000, 16'h0010}, {1'b1, 16'h0000, 16'h0000}, n);
    do_scan(IDLE, 1'b0, {1'b1, 16'h0000, 16'h0000}, {1'b1, 16'h0000, 16'h0000}, n);
    do_scan(P_A,  1'b0, {1'b1, 16'h0000, 16'h0010}, {1'b1, 16'h0000, 16'h0000}, n);
    do_scan(P_A,  1'b0, {1'b1, 16'h0000, 16'h0010}, {1'b1, 16'h0000, 16'h0010}, n);

    // Stuck-low line, then release
    do_scan(IDLE, 1'b1, {1'b0, 16'h0000, 16'h0000}, {1'b0, 16'h0000, 16'h0000}, n);
    do_scan(IDLE, 1'b0, {1'b1, 16'h0000, 16'h0000}, {1'b0, 16'h0000, 16'h0000}, n);
    do_scan(IDLE, 1'b0, {1'b1, 16'h0000, 16'h0000}, {1'b1, 16'h0000, 16'h0000}, n);

    // Reset during CLK_HI of bit 10 (scan aborted, no scan_done expected)
    wait_load_fall(n);
    wait_load_rise();
    wait_rises(11);
    check("midscan_clk_high", 64'(joy_clk0), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_joy_clk",  64'(joy_clk0),  64'd0);
    check("midrst_joy_load", 64'(joy_load0), 64'd1);
    check("midrst_f0_outs",  64'({present0, j2_0, j1_0}), 64'd0);
    check("midrst_f1_outs",  64'({present1, j2_1, j1_1}), 64'd0);
    pattern = P_R;
    push({1'b1, 16'h0000, 16'h0001}, {1'b0, 16'h0000, 16'h0000});
    wait_load_fall(n);
    check("gap_after_midscan_reset", 64'(n), 64'd8);
    wait_done(n);

    // Enable dropped during CLK_LO of bit 5: scan completes, then scanning stops
    push({1'b1, 16'h0000, 16'h0001}, {1'b1, 16'h0000, 16'h0001});
    wait_load_fall(n);
    wait_load_rise();
    wait_rises(5);
    k = 0;
    while (joy_clk0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    enable = 1'b0;
    wait_done(n);
    act = 0;
    repeat (600) begin
      @(negedge clk);
      if (!joy_load0 || joy_clk0 || done0) act++;
    end
    check("disabled_activity", 64'(act), 64'd0);
    check("disabled_hold_f0", 64'({present0, j2_0, j1_0}), {31'd0, 1'b1, 16'h0000, 16'h0001});
    enable = 1'b1;
    push({1'b1, 16'h0000, 16'h0001}, {1'b1, 16'h0000, 16'h0001});
    wait_load_fall(n);
    check("gap_after_enable", 64'(n), 64'd8);
    wait_done(n);

    repeat (2) @(negedge clk);
    check("f0_queue_drained", 64'(q0.size()), 64'd0);
    check("f1_queue_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
